// File: rtl/uc_arb_if.sv
// ---------------------------------------------------------------------------
// uc_arb_if -- queue-side bundle of the unit-clause arbiter.
//
// Groups the UCQ_in drain handshake and the UCQ_out broadcast handshake.
//   UCQ_in_empty        per-proc UCQ_in empty flag          (queue -> arbiter)
//   UCQ_in2uarb_uc      per-proc UCQ_in head literal        (queue -> arbiter)
//                       proc i occupies bits [i*LIT_W +: LIT_W]
//   ucarb2UCQ_in_pop    one-hot pop of the granted UCQ_in   (arbiter -> queue)
//   UCQ_out_full        per-proc UCQ_out full flag          (queue -> arbiter)
//   ucarb2UCQ_out_push  broadcast push, all bits equal      (arbiter -> queue)
//   ucarb2UCQ_out_uc    broadcast literal                   (arbiter -> queue)
// Modports: master = arbiter side, slave = queue side.
// ---------------------------------------------------------------------------
interface uc_arb_if #(
    parameter int N_PROC = 4,
    parameter int LIT_W  = 9
);
    logic [N_PROC-1:0]       UCQ_in_empty;
    logic [N_PROC*LIT_W-1:0] UCQ_in2uarb_uc;
    logic [N_PROC-1:0]       ucarb2UCQ_in_pop;
    logic [N_PROC-1:0]       UCQ_out_full;
    logic [N_PROC-1:0]       ucarb2UCQ_out_push;
    logic [LIT_W-1:0]        ucarb2UCQ_out_uc;

    modport master (
        input  UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
        output ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
    );

    modport slave (
        output UCQ_in_empty, UCQ_in2uarb_uc, UCQ_out_full,
        input  ucarb2UCQ_in_pop, ucarb2UCQ_out_push, ucarb2UCQ_out_uc
    );
endinterface

// File: rtl/uc_arb.sv
// ---------------------------------------------------------------------------
// uc_arb -- unit-clause arbiter.
//
// Round-robin drains every proc's UCQ_in, records each literal in a global
// assignment table, broadcasts new literals into every UCQ_out (all or
// nothing), merges per-proc conflicts and detects cross-proc contradictions.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-high
//   q              uc_arb_if.master: UCQ_in pop handshake, UCQ_out push
//   proc_conflict  per-proc BCP conflict; forces the terminal CONFLICT state
//   conflict       sticky global conflict
//   quiescent      idle in SCAN, all UCQ_in empty, no conflict
//   bcast_count    saturating count of broadcast literals
//
// Build option: define UCARB_DEDUP_EN to build the assignment table with
// duplicate drop and contradiction detection. Without it every popped
// literal is broadcast and conflict only follows proc_conflict.
// ---------------------------------------------------------------------------
module uc_arb #(
    parameter int N_PROC = 4,
    parameter int VAR_W  = 8,
    parameter int LIT_W  = VAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    uc_arb_if.master          q,
    input  logic [N_PROC-1:0] proc_conflict,
    output logic              conflict,
    output logic              quiescent,
    output logic [15:0]       bcast_count
);
    localparam int PTR_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

    typedef enum logic [1:0] {SCAN, CHECK, BCAST, CONFLICT} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LIT_W-1:0]  cur_lit_q, cur_lit_d;
    logic [15:0]       bcast_count_q, bcast_count_d;

    logic              grant_vld;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  grant_next;
    logic [LIT_W-1:0]  grant_lit;
    logic [N_PROC-1:0] pop_vec;
    logic              pc_any;
    logic              out_full_any;
    logic              push_fire;

`ifdef UCARB_DEDUP_EN
    localparam int TBL_N = 1 << VAR_W;
    logic [TBL_N-1:0]  assigned_q, assigned_d;
    logic [TBL_N-1:0]  value_q, value_d;
    logic [VAR_W-1:0]  cur_var;
    logic              cur_sign;

    assign cur_var  = cur_lit_q[VAR_W-1:0];
    assign cur_sign = cur_lit_q[LIT_W-1];
`endif

    assign pc_any       = |proc_conflict;
    assign out_full_any = |q.UCQ_out_full;

    // First non-empty queue at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx        = 0;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_next = '0;
        grant_lit  = '0;
        for (int k = 0; k < N_PROC; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_PROC;
            if (!grant_vld && !q.UCQ_in_empty[idx]) begin
                grant_vld  = 1'b1;
                grant_idx  = PTR_W'(idx);
                grant_next = PTR_W'((idx + 1) % N_PROC);
                grant_lit  = q.UCQ_in2uarb_uc[idx*LIT_W +: LIT_W];
            end
        end
    end

    // Handshakes are gated by rst so an abandoned BCAST never pushes, and by
    // any proc conflict so a same-cycle conflict wins over pop/push.
    always_comb begin
        pop_vec = '0;
        if (!rst && !pc_any && state_q == SCAN && grant_vld) begin
            pop_vec[grant_idx] = 1'b1;
        end
    end

    assign push_fire = !rst && !pc_any && state_q == BCAST && !out_full_any;

    assign q.ucarb2UCQ_in_pop   = pop_vec;
    assign q.ucarb2UCQ_out_push = {N_PROC{push_fire}};
    assign q.ucarb2UCQ_out_uc   = cur_lit_q;
    assign conflict             = !rst && state_q == CONFLICT;
    assign quiescent            = !rst && state_q == SCAN && (&q.UCQ_in_empty) && !pc_any;
    assign bcast_count          = bcast_count_q;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_lit_d     = cur_lit_q;
        bcast_count_d = bcast_count_q;
`ifdef UCARB_DEDUP_EN
        assigned_d    = assigned_q;
        value_d       = value_q;
`endif
        if (pc_any) begin
            state_d = CONFLICT;
        end else begin
            case (state_q)
                SCAN: begin
                    if (grant_vld) begin
                        cur_lit_d = grant_lit;
                        rr_ptr_d  = grant_next;
                        state_d   = CHECK;
                    end
                end
                CHECK: begin
`ifdef UCARB_DEDUP_EN
                    // Table stores the variable's value, i.e. the inverted sign.
                    if (!assigned_q[cur_var]) begin
                        assigned_d[cur_var] = 1'b1;
                        value_d[cur_var]    = ~cur_sign;
                        state_d             = BCAST;
                    end else if (value_q[cur_var] == ~cur_sign) begin
                        state_d = SCAN;
                    end else begin
                        state_d = CONFLICT;
                    end
`else
                    state_d = BCAST;
`endif
                end
                BCAST: begin
                    if (!out_full_any) begin
                        if (bcast_count_q != 16'hFFFF) begin
                            bcast_count_d = bcast_count_q + 16'd1;
                        end
                        state_d = SCAN;
                    end
                end
                CONFLICT: state_d = CONFLICT;
                default:  state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCAN;
            rr_ptr_q      <= '0;
            cur_lit_q     <= '0;
            bcast_count_q <= '0;
`ifdef UCARB_DEDUP_EN
            assigned_q    <= '0;
            value_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_lit_q     <= cur_lit_d;
            bcast_count_q <= bcast_count_d;
`ifdef UCARB_DEDUP_EN
            assigned_q    <= assigned_d;
            value_q       <= value_d;
`endif
        end
    end
endmodule

// File: tb/tb_uc_arb.sv
// ---------------------------------------------------------------------------
// tb_uc_arb -- self-checking bench for uc_arb.
//
// The bench owns one FIFO per proc feeding UCQ_in. A cycle-level reference
// model (round-robin grant, assignment table as an associative array,
// expected-broadcast queue) predicts every pop, push, conflict and count;
// a negedge monitor compares the DUT against it. Follows UCARB_DEDUP_EN.
// ---------------------------------------------------------------------------
module tb_uc_arb;
    localparam int N     = 4;
    localparam int VAR_W = 8;
    localparam int LIT_W = VAR_W + 1;
    localparam int DEPTH = 64;
    localparam int INF   = 32'h7fff_ffff;

    typedef struct {
        logic [LIT_W-1:0] lit;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b1;
    logic [N-1:0]     full_r = '0;
    logic [N-1:0]     pc_r = '0;
    logic             conflict;
    logic             quiescent;
    logic [15:0]      bcast_count;
    logic [N-1:0]     in_empty;
    logic [N*LIT_W-1:0] in_lit;

    logic [LIT_W-1:0] mem [N][DEPTH];
    int               head [N];
    int               tail [N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    exp_t exp_q[$];
    bit   tbl[int];
    int   m_rr = 0;
    int   m_cnt = 0;
    int   conf_due = -1;
    int   scan_from = 0;
    int   pop_log[$];

    uc_arb_if #(.N_PROC(N), .LIT_W(LIT_W)) qif ();

    uc_arb #(.N_PROC(N), .VAR_W(VAR_W), .LIT_W(LIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .q            (qif),
        .proc_conflict(pc_r),
        .conflict     (conflict),
        .quiescent    (quiescent),
        .bcast_count  (bcast_count)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // UCQ_in FIFOs
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (flush) head[i] <= tail[i];
            else if (qif.ucarb2UCQ_in_pop[i] && head[i] != tail[i]) head[i] <= head[i] + 1;
        end
    end

    always_comb begin
        in_empty = '0;
        in_lit   = '0;
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (head[i] == tail[i]);
            in_lit[i*LIT_W +: LIT_W] = mem[i][head[i] % DEPTH];
        end
    end

    assign qif.UCQ_in_empty   = in_empty;
    assign qif.UCQ_in2uarb_uc = in_lit;
    assign qif.UCQ_out_full   = full_r;

    function automatic void chk(string nm, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // Monitor: compare DUT against the reference model every cycle.
    always @(negedge clk) begin
        logic [N-1:0]     exp_pop;
        logic [N-1:0]     exp_push;
        logic [LIT_W-1:0] lit;
        exp_t             e;
        int               g;
        int               v;
        bit               m_conf;
        bit               pc_any;
        bit               full_any;
        pc_any   = |pc_r;
        full_any = |full_r;
        if (rst) begin
            chk("rst_pop", qif.ucarb2UCQ_in_pop, 0);
            chk("rst_push", qif.ucarb2UCQ_out_push, 0);
            exp_q.delete();
            tbl.delete();
            m_rr = 0;
            m_cnt = 0;
            conf_due = -1;
            scan_from = 0;
        end else begin
            m_conf = (conf_due >= 0 && cyc >= conf_due);
            chk("conflict", conflict, m_conf);
            chk("bcast_count", bcast_count, m_cnt);
            chk("quiescent", quiescent, (cyc >= scan_from) && (&in_empty) && !m_conf && !pc_any);

            exp_push = '0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].cyc + 2 && !full_any && !pc_any && !m_conf)
                exp_push = '1;
            chk("push", qif.ucarb2UCQ_out_push, exp_push);
            if (exp_push != 0) begin
                e = exp_q.pop_front();
                chk("push_uc", qif.ucarb2UCQ_out_uc, e.lit);
                if (m_cnt < 65535) m_cnt++;
                scan_from = cyc + 1;
            end

            g = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (g < 0 && head[idx] != tail[idx]) g = idx;
            end
            exp_pop = '0;
            if (cyc >= scan_from && !m_conf && !pc_any && g >= 0) exp_pop[g] = 1'b1;
            chk("pop", qif.ucarb2UCQ_in_pop, exp_pop);
            if (exp_pop != 0) begin
                lit = mem[g][head[g] % DEPTH];
                pop_log.push_back(g);
                m_rr = (g + 1) % N;
                scan_from = INF;
`ifdef UCARB_DEDUP_EN
                v = int'(lit[VAR_W-1:0]);
                if (!tbl.exists(v)) begin
                    tbl[v] = ~lit[LIT_W-1];
                    exp_q.push_back('{lit, cyc});
                end else if (tbl[v] == ~lit[LIT_W-1]) begin
                    scan_from = cyc + 2;
                end else begin
                    if (conf_due < 0 || conf_due > cyc + 2) conf_due = cyc + 2;
                end
`else
                v = 0;
                exp_q.push_back('{lit, cyc});
`endif
            end

            if (pc_any) begin
                if (conf_due < 0 || conf_due > cyc + 1) conf_due = cyc + 1;
                exp_q.delete();
                scan_from = INF;
            end
        end
    end

    task automatic put(int p, logic [LIT_W-1:0] l);
        mem[p][tail[p] % DEPTH] = l;
        tail[p] = tail[p] + 1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; flush = 1'b1; full_r = '0; pc_r = '0;
        @(posedge clk);
        @(negedge clk); #2;
        chk("reset_pop", qif.ucarb2UCQ_in_pop, 0);
        chk("reset_push", qif.ucarb2UCQ_out_push, 0);
        chk("reset_uc", qif.ucarb2UCQ_out_uc, 0);
        chk("reset_conflict", conflict, 0);
        chk("reset_quiescent", quiescent, 0);
        chk("reset_bcast_count", bcast_count, 0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        pop_log.delete();
    endtask

    task automatic wait_idle(string nm);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 3000) begin
            @(negedge clk); #2;
            ok = (&in_empty) && exp_q.size() == 0 && quiescent && !conflict;
            n++;
        end
        chk(nm, ok, 1);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [LIT_W-1:0] l;
        int v;
        int p;

        // Single literal from proc 1
        do_reset();
        put(1, 9'h005);
        wait_idle("single_idle");
        chk("single_count", bcast_count, 1);
        chk("single_grant", (pop_log.size() == 1) ? pop_log[0] : -1, 1);

        // Round robin across all four queues
        do_reset();
        put(0, 9'h010); put(1, 9'h021); put(2, 9'h032); put(3, 9'h043);
        wait_idle("rr_idle");
        chk("rr_count", bcast_count, 4);
        chk("rr_npops", pop_log.size(), 4);
        for (int i = 0; i < 4 && i < pop_log.size(); i++) chk("rr_order", pop_log[i], i);

        // Duplicate and contradiction
        do_reset();
        put(0, 9'h003); put(2, 9'h003);
        wait_idle("dup_idle");
`ifdef UCARB_DEDUP_EN
        chk("dup_count", bcast_count, 1);
`else
        chk("dup_count", bcast_count, 2);
`endif
        tick(1);
        put(1, 9'h103);
        tick(6);
`ifdef UCARB_DEDUP_EN
        chk("contra_conflict", conflict, 1);
`else
        chk("contra_conflict", conflict, 0);
`endif
        put(0, 9'h007);
        tick(8);
        @(negedge clk); #2;
`ifdef UCARB_DEDUP_EN
        chk("contra_no_pop", in_empty[0], 0);
        chk("contra_count", bcast_count, 1);
`else
        chk("contra_no_pop", in_empty[0], 1);
        chk("contra_count", bcast_count, 4);
`endif

        // Backpressure: UCQ_out_full[2] held for 5 BCAST cycles
        do_reset();
        put(0, 9'h00A);
        tick(2);
        full_r = 4'b0100;
        tick(5);
        full_r = '0;
        wait_idle("bp_idle");
        chk("bp_count", bcast_count, 1);

        // Proc conflict in the same cycle as the push
        do_reset();
        put(2, 9'h011);
        tick(2);
        pc_r = 4'b1000;
        tick(1);
        pc_r = '0;
        tick(4);
        @(negedge clk); #2;
        chk("pc_conflict_sticky", conflict, 1);
        chk("pc_count", bcast_count, 0);

        // Reset while holding in BCAST, then resend the same literal
        do_reset();
        full_r = 4'b0001;
        put(3, 9'h044);
        tick(3);
        rst = 1'b1;
        full_r = '0;
        tick(1);
        rst = 1'b0;
        @(negedge clk); #2;
        chk("rstb_push", qif.ucarb2UCQ_out_push, 0);
        chk("rstb_uc", qif.ucarb2UCQ_out_uc, 0);
        chk("rstb_count", bcast_count, 0);
        chk("rstb_conflict", conflict, 0);
        tick(1);
        put(3, 9'h044);
        wait_idle("rstb_idle");
        chk("rstb_resend_count", bcast_count, 1);

        // Random traffic, consistent signs per variable
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick(1);
            if ($urandom % 4 == 0) begin
                p = int'($urandom % N);
                v = int'($urandom % 16);
                l = '0;
                l[VAR_W-1:0] = VAR_W'(v);
                l[LIT_W-1] = (v % 3 == 0);
                if (tail[p] - head[p] < 48) put(p, l);
            end
            full_r = ($urandom % 3 == 0) ? N'($urandom) : '0;
        end
        full_r = '0;
        wait_idle("rand_idle");
        chk("rand_count", bcast_count, m_cnt);

        // Random traffic with random signs (may end in a contradiction)
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick(1);
            if ($urandom % 4 == 0) begin
                p = int'($urandom % N);
                l = '0;
                l[VAR_W-1:0] = VAR_W'($urandom % 24);
                l[LIT_W-1] = 1'($urandom);
                if (tail[p] - head[p] < 48) put(p, l);
            end
            full_r = ($urandom % 4 == 0) ? N'($urandom) : '0;
        end
        full_r = '0;
        tick(200);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uc_arb.md
# uc_arb

Unit-clause arbiter on the processor side of the UCQ protocol. It round-robin drains the `UCQ_in` queue of every `proc` (the implications produced by each BCP engine) and records each literal in a global assignment table. Each new literal is broadcast into every `proc`'s `UCQ_out` queue. It also merges per-proc conflicts and detects cross-proc contradictions, which makes it the single point that decides global conflict and quiescence.

## Interface
- `N_PROC`, 4: number of `proc` instances served (≥2).
- `VAR_W`, 8: variable index width; the table has 2^VAR_W entries.
- `LIT_W`, VAR_W+1: literal width, `{sign, var}`; sign=1 means negated.
- `clk`  in  1  clock, the single clock.
- `rst`  in  1  synchronous reset, active-high.
- `UCQ_in_empty`  in  N_PROC  per-proc `UCQ_in` empty flag.
- `UCQ_in2uarb_uc`  in  N_PROC*LIT_W  per-proc `UCQ_in` head literal; proc i occupies bits [i*LIT_W +: LIT_W].
- `ucarb2UCQ_in_pop`  out  N_PROC  one-hot pop of the granted `UCQ_in`.
- `UCQ_out_full`  in  N_PROC  per-proc `UCQ_out` full flag.
- `ucarb2UCQ_out_push`  out  N_PROC  broadcast push; all bits are always equal.
- `ucarb2UCQ_out_uc`  out  LIT_W  broadcast literal.
- `proc_conflict`  in  N_PROC  per-proc BCP conflict.
- `conflict`  out  1  sticky global conflict.
- `quiescent`  out  1  arbiter is in SCAN, all `UCQ_in` are empty, and there is no conflict.
- `bcast_count`  out  16  saturating count of broadcast literals.

## Operation
- **FSM states:** SCAN, CHECK, BCAST, CONFLICT.
- **SCAN:**
  - Pick the first i, searching from `rr_ptr` upward with wrap, such that `UCQ_in_empty[i]`=0.
  - Pulse `ucarb2UCQ_in_pop[i]` for 1 cycle and latch `UCQ_in2uarb_uc[i]` into `cur_lit` on the same edge.
  - Set `rr_ptr` = i+1 mod N_PROC and go to CHECK.
  - If every queue is empty, stay in SCAN with no pop.
- **CHECK** (reads table entry `{assigned, value}` at `cur_lit[VAR_W-1:0]`):
  - Unassigned: write `{1, ~sign}` and go to BCAST.
  - Assigned, same value: drop the literal as a duplicate and go to SCAN.
  - Assigned, opposite value: go to CONFLICT.
- **BCAST:**
  - Hold while any `UCQ_out_full` bit is 1.
  - Otherwise pulse all `ucarb2UCQ_out_push` bits for 1 cycle with `ucarb2UCQ_out_uc`=`cur_lit`, increment `bcast_count` (saturating at 0xFFFF), and go to SCAN.
- **CONFLICT:** terminal. `conflict`=1; no pops and no pushes until `rst`.
- **Per-proc conflict:** any `proc_conflict` bit =1 in any state sends the FSM to CONFLICT on the next edge. This overrides a same-cycle push or pop: pop and push are gated by `~|proc_conflict`.
- **Broadcast semantics:** all-or-nothing. No proc receives a literal unless all procs receive it in the same cycle.
- **Broadcast timing:** `ucarb2UCQ_out_uc` is only meaningful while push is high; it holds `cur_lit` otherwise.

## Timing
- **Reset values:** every output is 0. FSM=SCAN, `rr_ptr`=0, `cur_lit`=0, table all unassigned, `bcast_count`=0.
- **Reset mid-operation:** discards `cur_lit` and clears the table on the next edge. An in-flight BCAST is abandoned without a push.
- **Latency:** pop at cycle t, CHECK at t+1, push at t+2 when no `UCQ_out` is full. Peak throughput is 1 literal per 3 cycles.
- **Pop timing:** `ucarb2UCQ_in_pop` is combinational from state and `UCQ_in_empty`, so the pop is never issued to an empty queue.
- **Grant order:** for simultaneous non-empty queues, grants follow strict round robin. Example with N_PROC=4, `rr_ptr`=3, and procs 0 and 3 non-empty: proc 3 is granted first, then proc 0.
- **Push timing:** push depends on the registered state and the current `UCQ_out_full`. A full flag that rises in the same cycle blocks the push.
- **Quiescence:** `quiescent` is combinational. It may be 1 in SCAN only, never in CHECK or BCAST.

## Configuration
- **`UCARB_DEDUP_EN` defined:** the assignment table, duplicate drop, and contradiction detection are built as described above.
- **`UCARB_DEDUP_EN` undefined:**
  - No table is instantiated; CHECK always proceeds to BCAST, so every popped literal is broadcast.
  - `conflict` reflects only the sticky OR of `proc_conflict`.
  - Latency and handshakes are unchanged.

## Test plan
- **Single literal:** proc 1 `UCQ_in` holds 0x05, all `UCQ_out` not full -> pop[1] at t, push=4'b1111 with uc=0x05 at t+2, `bcast_count`=1.
- **Round robin:** `rr_ptr`=0 and all 4 queues each hold one distinct literal -> pops in order 0,1,2,3 at 3-cycle spacing and 4 broadcasts.
- **Duplicate and contradiction** (with `UCARB_DEDUP_EN`):
  - Proc 0 pushes 0x03 and proc 2 pushes 0x03 -> one broadcast.
  - Proc 1 then pushes 0x103 (~x3) -> `conflict`=1 two cycles after its pop, with no further pops or pushes.
- **Backpressure:** a literal is in BCAST and `UCQ_out_full[2]` is held high for 5 cycles -> no push bit rises during those cycles; all 4 push bits pulse on the cycle after full drops, and the value is unchanged.
- **Proc conflict:** `proc_conflict[3]` is pulsed in the same cycle as a BCAST push -> the push is suppressed and `conflict` is 1 on the next cycle and stays 1.
- **Reset mid-BCAST:** `rst` is asserted for 1 cycle while in BCAST -> no push occurs, all outputs are 0, and re-sending the same literal is broadcast again because the table was cleared.
